// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI transmitter among several valid/ready/last
// frame streams; a grant lasts one transaction and is followed by an idle gap.
`timescale 1ns/1ps
module spi_tx_arbiter #(
    parameter int P_NUM_REQ    = 4,
    parameter int P_DATA_WIDTH = 8,
    parameter int P_GAP_CYCLES = 4,
    parameter int P_TIMEOUT    = 255
) (
    input  logic                              clk_100,
    input  logic                              s_rst,
    input  logic [P_NUM_REQ-1:0]              req_valid,
    input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] req_data,
    input  logic [P_NUM_REQ-1:0]              req_last,
    output logic [P_NUM_REQ-1:0]              req_ready,
    output logic                              tx_valid,
    output logic [P_DATA_WIDTH-1:0]           tx_data,
    input  logic                              tx_ready,
    output logic [$clog2(P_NUM_REQ)-1:0]      gnt_id,
    output logic                              gnt_active,
    output logic                              err_timeout
);

    localparam int IW = $clog2(P_NUM_REQ);
    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam int GW = (P_GAP_CYCLES > 0) ? $clog2(P_GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(P_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(P_GAP_CYCLES - 1);
    localparam logic [IW-1:0] PTR_RST  = IW'(P_NUM_REQ - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE, ST_GAP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [TW-1:0]   to_q, to_d;

    logic [P_DATA_WIDTH-1:0] lane_data [P_NUM_REQ];
    logic            g_valid, g_last;
    logic            win_found;
    logic [IW-1:0]   win_id, cand;

    for (genvar gi = 0; gi < P_NUM_REQ; gi++) begin : g_lane
        assign lane_data[gi] = req_data[gi*P_DATA_WIDTH +: P_DATA_WIDTH];
    end

    assign g_valid    = req_valid[gnt_q];
    assign g_last     = req_last[gnt_q];
    assign tx_data    = lane_data[gnt_q];
    assign gnt_id     = gnt_q;
    assign gnt_active = (state_q != ST_IDLE);

    // Scan starts just after the last winner so every waiting requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= P_NUM_REQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % P_NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        gap_d       = gap_q;
        to_d        = to_q;
        tx_valid    = 1'b0;
        req_ready   = '0;
        err_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gap_d = '0;
                to_d  = '0;
                if (win_found) begin
                    gnt_d   = win_id;
                    ptr_d   = win_id;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid         = g_valid;
                req_ready[gnt_q] = tx_ready;
                if (g_valid) begin
                    to_d = '0;
                    if (tx_ready && g_last) state_d = ST_DONE;
                end else if (to_q >= TO_LAST) begin
                    // This is the P_TIMEOUT-th consecutive cycle without a frame.
                    err_timeout = 1'b1;
                    to_d        = '0;
                    state_d     = ST_DONE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (tx_ready) begin
                    gap_d   = '0;
                    state_d = (P_GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= PTR_RST;
            gap_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: requester frame queues and a busy-counter
// transmitter model are advanced once per clock; a second instance has no gap.
`timescale 1ns/1ps
module tb_spi_tx_arbiter;

    logic        clk = 1'b0;
    logic        s_rst;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        tx_valid, tx_ready, gnt_active, err_timeout;
    logic [7:0]  tx_data;
    logic [1:0]  gnt_id;

    logic [3:0]  r2_valid, r2_last, r2_ready;
    logic [31:0] r2_data;
    logic        t2_valid, t2_ready, g2_act, e2_timeout;
    logic [7:0]  t2_data;
    logic [1:0]  g2_id;

    int errors = 0;
    int checks = 0;

    logic [7:0] fr_data [4][8];
    logic       fr_last [4][8];
    int         fr_n [4];
    int         fr_p [4];
    int         busy, busy_len, acc_cnt;
    int         n, m, k, idle, cyc, other, ecount, a0;
    logic [1:0] exp_id [6];
    logic [7:0] exp_dat [6];

    always #5 clk = ~clk;

    spi_tx_arbiter #(.P_NUM_REQ(4), .P_DATA_WIDTH(8), .P_GAP_CYCLES(4), .P_TIMEOUT(255)) dut (
        .clk_100(clk), .s_rst(s_rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .gnt_id(gnt_id), .gnt_active(gnt_active), .err_timeout(err_timeout)
    );

    spi_tx_arbiter #(.P_NUM_REQ(4), .P_DATA_WIDTH(8), .P_GAP_CYCLES(0), .P_TIMEOUT(255)) dut_nogap (
        .clk_100(clk), .s_rst(s_rst), .req_valid(r2_valid), .req_data(r2_data),
        .req_last(r2_last), .req_ready(r2_ready), .tx_valid(t2_valid), .tx_data(t2_data),
        .tx_ready(t2_ready), .gnt_id(g2_id), .gnt_active(g2_act), .err_timeout(e2_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (fr_p[i] < fr_n[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*8 +: 8]    = fr_data[i][fr_p[i]];
                req_last[i]           = fr_last[i][fr_p[i]];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*8 +: 8]    = 8'h00;
                req_last[i]           = 1'b0;
            end
        end
        tx_ready = (busy == 0);
    endtask

    task automatic push(input int lane, input logic [7:0] d, input logic l);
        fr_data[lane][fr_n[lane]] = d;
        fr_last[lane][fr_n[lane]] = l;
        fr_n[lane]++;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic adv();
        logic [3:0] acc;
        logic       tacc;
        acc  = req_valid & req_ready;
        tacc = tx_valid & tx_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (acc[i]) fr_p[i]++;
        if (tacc) begin
            busy = busy_len;
            acc_cnt++;
        end else if (busy > 0) begin
            busy--;
        end
        drive();
        @(negedge clk);
    endtask

    initial begin
        s_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin fr_n[i] = 0; fr_p[i] = 0; end
        busy = 0; busy_len = 18; acc_cnt = 0;
        r2_valid = 4'b0; r2_data = 32'h0; r2_last = 4'b0; t2_ready = 1'b1;
        drive();
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt_id", 32'(gnt_id), 0);
        chk("rst_gnt_active", 32'(gnt_active), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_nogap_active", 32'(g2_act), 0);
        s_rst = 1'b0;
        adv();

        // Single frame from requester 1, transmitter busy 18 cycles.
        push(1, 8'hA5, 1'b1);
        drive();
        chk("t1_idle_active", 32'(gnt_active), 0);
        chk("t1_idle_txv", 32'(tx_valid), 0);
        adv();
        chk("t1_gnt_id", 32'(gnt_id), 1);
        chk("t1_active", 32'(gnt_active), 1);
        chk("t1_txv", 32'(tx_valid), 1);
        chk("t1_data", 32'(tx_data), 32'hA5);
        chk("t1_ready", 32'(req_ready), 32'h2);
        a0 = acc_cnt;
        adv();
        n = 0; other = 0;
        while (gnt_active && n < 100) begin
            if ((req_ready & 4'b1101) != 4'b0) other = 1;
            if (tx_valid) other = 1;
            n++;
            adv();
        end
        chk("t1_hold_len", n, 23);
        chk("t1_accepts", acc_cnt - a0, 1);
        chk("t1_no_stray", other, 0);

        // Burst of three frames from requester 0 with an always-ready transmitter.
        busy_len = 0;
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b1);
        drive();
        adv();
        chk("t2_d0", 32'(tx_data), 32'h11);
        chk("t2_g0", 32'(gnt_id), 0);
        chk("t2_r0", 32'(req_ready), 32'h1);
        adv();
        chk("t2_d1", 32'(tx_data), 32'h22);
        chk("t2_v1", 32'(tx_valid), 1);
        chk("t2_g1", 32'(gnt_id), 0);
        adv();
        chk("t2_d2", 32'(tx_data), 32'h33);
        chk("t2_v2", 32'(tx_valid), 1);
        chk("t2_g2", 32'(gnt_id), 0);
        adv();
        n = 0;
        while (gnt_active && n < 100) begin n++; adv(); end
        chk("t2_tail_len", n, 5);

        // Reset so the rotation starts from requester 0.
        s_rst = 1'b1;
        adv();
        s_rst = 1'b0;
        chk("t3_rst_active", 32'(gnt_active), 0);

        // Contention among requesters 0, 2, 3, two single-frame transactions each.
        busy_len = 2;
        for (int f = 0; f < 2; f++) begin
            push(0, 8'hC0 + 8'(f), 1'b1);
            push(2, 8'hE0 + 8'(f), 1'b1);
            push(3, 8'hF0 + 8'(f), 1'b1);
        end
        exp_id  = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
        exp_dat = '{8'hC0, 8'hE0, 8'hF0, 8'hC1, 8'hE1, 8'hF1};
        drive();
        k = 0; idle = 0; cyc = 0;
        while (k < 6 && cyc < 400) begin
            if (tx_valid && tx_ready) begin
                chk("t3_order", 32'(gnt_id), 32'(exp_id[k]));
                chk("t3_data", 32'(tx_data), 32'(exp_dat[k]));
                if (k > 0) chk("t3_idle_gap", idle, 8);
                idle = 0;
                k++;
            end else if (!tx_valid) begin
                idle++;
            end
            adv();
            cyc++;
        end
        chk("t3_count", k, 6);
        cyc = 0;
        while (gnt_active && cyc < 100) begin cyc++; adv(); end

        // Timeout: requester 2 stalls after a non-final frame; requester 3 waits.
        push(2, 8'h5A, 1'b0);
        push(3, 8'h3C, 1'b1);
        drive();
        adv();
        chk("t4_gnt2", 32'(gnt_id), 2);
        chk("t4_data", 32'(tx_data), 32'h5A);
        chk("t4_txv", 32'(tx_valid), 1);
        adv();
        n = 0;
        while (n < 400) begin
            n++;
            if (err_timeout) break;
            adv();
        end
        chk("t4_timeout_len", n, 255);
        chk("t4_err_txv", 32'(tx_valid), 0);
        chk("t4_err_active", 32'(gnt_active), 1);
        busy = 4;
        adv();
        m = 0; ecount = 0;
        while (gnt_active && m < 100) begin
            m++;
            if (err_timeout) ecount++;
            adv();
        end
        chk("t4_done_gap_len", m, 8);
        chk("t4_err_once", ecount, 0);
        adv();
        chk("t4_next_gnt", 32'(gnt_id), 3);
        chk("t4_next_txv", 32'(tx_valid), 1);
        chk("t4_next_data", 32'(tx_data), 32'h3C);
        cyc = 0;
        adv();
        while (gnt_active && cyc < 100) begin cyc++; adv(); end

        // Reset while requester 1 is presenting the second frame of a burst.
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b1);
        drive();
        adv();
        chk("t5_gnt1", 32'(gnt_id), 1);
        chk("t5_d0", 32'(tx_data), 32'h41);
        adv();
        chk("t5_d1", 32'(tx_data), 32'h42);
        chk("t5_d1_txv", 32'(tx_valid), 1);
        s_rst = 1'b1;
        push(0, 8'h07, 1'b1);
        drive();
        adv();
        chk("t5_rst_txv", 32'(tx_valid), 0);
        chk("t5_rst_active", 32'(gnt_active), 0);
        chk("t5_rst_gnt", 32'(gnt_id), 0);
        chk("t5_rst_ready", 32'(req_ready), 0);
        s_rst = 1'b0;
        adv();
        chk("t5_win0", 32'(gnt_id), 0);
        chk("t5_win0_active", 32'(gnt_active), 1);
        chk("t5_win0_data", 32'(tx_data), 32'h07);

        // Zero-gap instance: requesters 0 and 1 back to back.
        r2_valid = 4'b0011;
        r2_last  = 4'b0011;
        r2_data  = 32'h0000_8281;
        chk("t6_idle", 32'(g2_act), 0);
        adv();
        chk("t6_gnt0", 32'(g2_id), 0);
        chk("t6_txv0", 32'(t2_valid), 1);
        chk("t6_data0", 32'(t2_data), 32'h81);
        @(posedge clk);
        #1;
        r2_valid = 4'b0010;
        t2_ready = 1'b0;
        @(negedge clk);
        chk("t6_done_txv", 32'(t2_valid), 0);
        chk("t6_done_active", 32'(g2_act), 1);
        @(posedge clk);
        #1;
        t2_ready = 1'b1;
        @(negedge clk);
        chk("t6_done_wait", 32'(g2_act), 1);
        adv();
        chk("t6_idle_after", 32'(g2_act), 0);
        adv();
        chk("t6_gnt1", 32'(g2_id), 1);
        chk("t6_gnt1_active", 32'(g2_act), 1);
        chk("t6_data1", 32'(t2_data), 32'h82);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
